// File: rtl/note_scheduler.sv
// note_scheduler: scrolls chart ROM rows through a 16-row note window
// and judges strums against the hit-line row, keeping a hit score.
module note_scheduler #(
    parameter int ADDR_W              = 8,
    parameter int SONG_LEN            = 256,
    parameter int MAX_NOTES_ON_SCREEN = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              beat_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    input  logic [3:0]        disp_row,
    output logic [3:0]        disp_notes,
    input  logic              strum,
    input  logic [3:0]        frets,
    output logic              hit,
    output logic              miss,
    output logic [15:0]       score,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = MAX_NOTES_ON_SCREEN;
    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(SONG_LEN);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FETCH,
        LOAD,
        DONE
    } state_t;

    state_t          state_q;
    logic [3:0]      window_q [DEPTH];
    logic [ADDR_W:0] ptr_q;
    logic            judged_q;
    logic            hit_q;
    logic            miss_q;
    logic [15:0]     score_q;
    logic            busy_q;
    logic            done_q;

    logic            row0_live_d;
    logic            strum_ok_d;
    logic            strum_hit_d;
    logic            strum_miss_d;
    logic            tick_miss_d;
    logic            upper_empty_d;
    logic            more_rows_d;

    assign rom_addr   = ptr_q[ADDR_W-1:0];
    assign disp_notes = window_q[disp_row];
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign score      = score_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Judge decisions: a strum is resolved before a same-cycle tick.
    always_comb begin
        row0_live_d  = (window_q[0] != 4'b0) && !judged_q;
        strum_ok_d   = (state_q == RUN) && strum && row0_live_d;
        strum_hit_d  = strum_ok_d && (frets == window_q[0]);
        strum_miss_d = strum_ok_d && (frets != window_q[0]);
        tick_miss_d  = (state_q == RUN) && beat_tick
                       && row0_live_d && !strum_ok_d;
        more_rows_d  = ptr_q < LEN;
        upper_empty_d = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            if (window_q[i] != 4'b0) begin
                upper_empty_d = 1'b0;
            end
        end
    end

    // Sequencer FSM with window scroll, judging and registered pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            judged_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                window_q[i] <= 4'b0;
            end
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        ptr_q    <= '0;
                        judged_q <= 1'b0;
                        score_q  <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) begin
                            window_q[i] <= 4'b0;
                        end
                    end
                end
                RUN: begin
                    if (strum_hit_d) begin
                        hit_q    <= 1'b1;
                        judged_q <= 1'b1;
                        if (score_q != 16'hFFFF) begin
                            score_q <= score_q + 16'd1;
                        end
                    end
                    if (strum_miss_d || tick_miss_d) begin
                        miss_q   <= 1'b1;
                        judged_q <= 1'b1;
                    end
                    if (beat_tick) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        window_q[i] <= window_q[i+1];
                    end
                    window_q[DEPTH-1] <= more_rows_d ? rom_data : 4'b0;
                    if (more_rows_d) begin
                        ptr_q <= ptr_q + ONE;
                    end
                    judged_q <= 1'b0;
                    if (!more_rows_d && upper_empty_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
